// File: rtl/i2c_target_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_rx
//   Receive-oriented I2C target. The raw bus lines are synchronised and
//   glitch-filtered. START/STOP and SCL edges are derived from the filtered
//   levels. A byte-level FSM then acknowledges its own address, captures
//   written bytes and returns the last written byte on reads.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   scl_in       raw SCL (asynchronous)
//   sda_in       raw SDA (asynchronous)
//   sda_oe       1 = pull SDA low, 0 = release (open-drain)
//   data_out     last byte received in a write transfer
//   data_valid   one-clk pulse when data_out is updated
//   busy         1 between an accepted START and an accepted STOP
//   addr_hit     1 while the current transfer is addressed to TARGET_ADDR
//   fsm_state_o  current FSM state (debug observation)
//
// Handshake: data_valid is a push-only strobe with no ready. A consumer must
// take data_out in the cycle data_valid is high. data_out then holds its
// value until the next completed write byte.
// ---------------------------------------------------------------------------
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h27,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       busy,
  output logic       addr_hit,
  output logic [2:0] fsm_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WDATA     = 3'd3,
    WDATA_ACK = 3'd4,
    RDATA     = 3'd5,
    RDATA_ACK = 3'd6,
    IGNORE    = 3'd7
  } state_t;

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  // -------------------------------------------------------------------------
  // Synchroniser, filter and edge detection
  // -------------------------------------------------------------------------
  logic          scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
  logic          scl_f_q, sda_f_q, scl_p_q, sda_p_q;
  logic [CW-1:0] scl_cnt_q, sda_cnt_q;

  // A filtered level only follows the synchronised input once the input has
  // disagreed with it for FILTER_LEN samples in a row; any agreeing sample
  // restarts the count, so short glitches are dropped entirely.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q  <= 1'b1;
      scl_s2_q  <= 1'b1;
      sda_s1_q  <= 1'b1;
      sda_s2_q  <= 1'b1;
      scl_f_q   <= 1'b1;
      sda_f_q   <= 1'b1;
      scl_p_q   <= 1'b1;
      sda_p_q   <= 1'b1;
      scl_cnt_q <= '0;
      sda_cnt_q <= '0;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      scl_p_q  <= scl_f_q;
      sda_p_q  <= sda_f_q;

      if (scl_s2_q == scl_f_q) begin
        scl_cnt_q <= '0;
      end else if (scl_cnt_q == CNT_MAX) begin
        scl_f_q   <= scl_s2_q;
        scl_cnt_q <= '0;
      end else begin
        scl_cnt_q <= scl_cnt_q + 1'b1;
      end

      if (sda_s2_q == sda_f_q) begin
        sda_cnt_q <= '0;
      end else if (sda_cnt_q == CNT_MAX) begin
        sda_f_q   <= sda_s2_q;
        sda_cnt_q <= '0;
      end else begin
        sda_cnt_q <= sda_cnt_q + 1'b1;
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_f_q & ~scl_p_q;
  assign scl_fall  = ~scl_f_q & scl_p_q;
  // SDA may only move while SCL is stable high for START/STOP to qualify.
  assign start_det = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
  assign stop_det  = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;

  // -------------------------------------------------------------------------
  // Byte-level FSM
  // -------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic       byte_done_q, byte_done_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       busy_q, busy_d;
  logic       addr_hit_q, addr_hit_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= '0;
      byte_done_q  <= 1'b0;
      ack_q        <= 1'b1;
      sda_oe_q     <= 1'b0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      addr_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
      byte_done_q  <= byte_done_d;
      ack_q        <= ack_d;
      sda_oe_q     <= sda_oe_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      busy_q       <= busy_d;
      addr_hit_q   <= addr_hit_d;
    end
  end

  // The address check excludes the general-call address even when
  // TARGET_ADDR is parameterised to zero.
  logic addr_match;
  assign addr_match = (shift_q[7:1] == TARGET_ADDR) && (shift_q[7:1] != 7'h00);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    byte_done_d  = byte_done_q;
    ack_d        = ack_q;
    sda_oe_d     = sda_oe_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    busy_d       = busy_q;
    addr_hit_d   = addr_hit_q;

    if (stop_det) begin
      state_d     = IDLE;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      addr_hit_d  = 1'b0;
      busy_d      = 1'b0;
    end else if (start_det) begin
      state_d     = ADDR;
      bit_cnt_d   = '0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      addr_hit_d  = 1'b0;
      busy_d      = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end

        // ADDR and WDATA share the receive shifter; byte_done marks that the
        // eighth bit has been sampled and the next SCL fall ends the byte.
        ADDR, WDATA: begin
          if (scl_rise && !byte_done_q) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            bit_cnt_d   = '0;
            if (state_q == ADDR) begin
              if (addr_match) begin
                sda_oe_d   = 1'b1;
                addr_hit_d = 1'b1;
                state_d    = ADDR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
              sda_oe_d     = 1'b1;
              state_d      = WDATA_ACK;
            end
          end
        end

        // The R/W bit is still sitting in shift_q[0] from the address byte.
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            if (!shift_q[0]) begin
              sda_oe_d = 1'b0;
              state_d  = WDATA;
            end else begin
              tx_d     = data_out_q;
              sda_oe_d = ~data_out_q[7];
              state_d  = RDATA;
            end
          end
        end

        WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            state_d     = WDATA;
          end
        end

        // bit_cnt counts bits already clocked out; after bit k's rising edge
        // the next fall presents bit 7-(k+1), i.e. index ~bit_cnt.
        RDATA: begin
          if (scl_rise && !byte_done_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              sda_oe_d    = 1'b0;
              byte_done_d = 1'b0;
              bit_cnt_d   = '0;
              state_d     = RDATA_ACK;
            end else begin
              sda_oe_d = ~tx_q[~bit_cnt_q];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            ack_d = sda_f_q;
          end else if (scl_fall) begin
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            if (!ack_q) begin
              tx_d     = data_out_q;
              sda_oe_d = ~data_out_q[7];
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = IGNORE;
            end
          end
        end

        IGNORE: begin
          sda_oe_d = 1'b0;
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe      = sda_oe_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign busy        = busy_q;
  assign addr_hit    = addr_hit_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_rx
//   Directed bench for i2c_target_rx. A bus-master model drives SCL/SDA over
//   a wired-AND SDA line. Each written byte is pushed into exp_q when it is
//   sent. An independent monitor pops exp_q on every data_valid pulse, and it
//   also tracks sda_oe activity and protocol violations.
// ---------------------------------------------------------------------------
module tb_i2c_target_rx;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WDATA_ACK = 3'd4;
  localparam logic [2:0] S_IGNORE    = 3'd7;

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       addr_hit;
  logic [2:0] fsm_state;

  // Open-drain bus: either side can pull SDA low.
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h27), .FILTER_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .scl_in     (scl_m),
    .sda_in     (sda_in),
    .sda_oe     (sda_oe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .addr_hit   (addr_hit),
    .fsm_state_o(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int tests_run;
  int tests_failed;
  int dv_cnt;
  int oe_cnt;
  int viol_cnt;
  logic dv_prev;
  int h;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    dv_cnt   = 0;
    oe_cnt   = 0;
    viol_cnt = 0;
    dv_prev  = 1'b0;
  end

  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_valid: data_out 0x%0h with empty queue", data_out);
      end else begin
        check("data_out_at_valid", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
    if (sda_oe) oe_cnt++;
    if (sda_oe && (fsm_state == S_IDLE || fsm_state == S_IGNORE)) viol_cnt++;
    if (data_valid && dv_prev) viol_cnt++;
    dv_prev = data_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(h / 2);
    scl_m = 1'b1; tick(h);
    sda_m = 1'b0; tick(h);
    scl_m = 1'b0; tick(h / 2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(h / 2);
    scl_m = 1'b1; tick(h);
    sda_m = 1'b1; tick(h);
  endtask

  // glitch=1 pulls SCL low for 2 clk in the middle of the high phase.
  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; tick(h / 2);
    scl_m = 1'b1;
    if (glitch) begin
      tick(h / 2);
      scl_m = 1'b0; tick(2);
      scl_m = 1'b1; tick(h / 2);
    end else begin
      tick(h);
    end
    scl_m = 1'b0; tick(h / 2);
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_idx, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i], (i == glitch_idx));
    sda_m = 1'b1; tick(h / 2);
    scl_m = 1'b1; tick(h / 2);
    ack = sda_in;
    tick(h / 2);
    scl_m = 1'b0; tick(h / 2);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; tick(h / 2);
      scl_m = 1'b1; tick(h / 2);
      b[i] = sda_in;
      tick(h / 2);
      scl_m = 1'b0; tick(h / 2);
    end
    send_bit(nack, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic       ack;
  logic [7:0] rd;
  int         dv_snap;
  int         oe_snap;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    h     = 50;
    scl_m = 1'b1;
    sda_m = 1'b1;
    rst   = 1'b0;
    tick(3);
    check("rst_sda_oe",     {31'h0, sda_oe},     32'h0);
    check("rst_data_out",   {24'h0, data_out},   32'h0);
    check("rst_data_valid", {31'h0, data_valid}, 32'h0);
    check("rst_busy",       {31'h0, busy},       32'h0);
    check("rst_addr_hit",   {31'h0, addr_hit},   32'h0);
    check("rst_state",      {29'h0, fsm_state},  {29'h0, S_IDLE});
    rst = 1'b1;
    tick(20);

    // Write 0x0C, 0x08 to 0x27 with a slow bus.
    h = 500;
    dv_snap = dv_cnt;
    i2c_start();
    check("w1_busy", {31'h0, busy}, 32'h1);
    write_byte(8'h4E, 8, ack);
    check("w1_addr_ack", {31'h0, ack}, 32'h0);
    check("w1_addr_hit", {31'h0, addr_hit}, 32'h1);
    exp_q.push_back(8'h0C);
    write_byte(8'h0C, 8, ack);
    check("w1_d0_ack", {31'h0, ack}, 32'h0);
    check("w1_d0_out", {24'h0, data_out}, 32'h0C);
    exp_q.push_back(8'h08);
    write_byte(8'h08, 8, ack);
    check("w1_d1_ack", {31'h0, ack}, 32'h0);
    check("w1_d1_out", {24'h0, data_out}, 32'h08);
    i2c_stop();
    tick(20);
    check("w1_dv_pulses", dv_cnt - dv_snap, 32'd2);
    check("w1_busy_end",  {31'h0, busy},     32'h0);
    check("w1_hit_end",   {31'h0, addr_hit}, 32'h0);
    check("w1_state_end", {29'h0, fsm_state}, {29'h0, S_IDLE});

    // Non-matching address 0x3F.
    h = 50;
    dv_snap = dv_cnt;
    oe_snap = oe_cnt;
    i2c_start();
    write_byte(8'h7E, 8, ack);
    check("nm_addr_nack", {31'h0, ack}, 32'h1);
    check("nm_addr_hit",  {31'h0, addr_hit}, 32'h0);
    check("nm_state",     {29'h0, fsm_state}, {29'h0, S_IGNORE});
    write_byte(8'h55, 8, ack);
    check("nm_data_nack", {31'h0, ack}, 32'h1);
    i2c_stop();
    tick(20);
    check("nm_oe_never", oe_cnt - oe_snap, 32'd0);
    check("nm_no_valid", dv_cnt - dv_snap, 32'd0);

    // Write 0xA5, repeated START, read it back twice (ACK then NACK).
    i2c_start();
    write_byte(8'h4E, 8, ack);
    check("rd_waddr_ack", {31'h0, ack}, 32'h0);
    exp_q.push_back(8'hA5);
    write_byte(8'hA5, 8, ack);
    check("rd_wdata_ack", {31'h0, ack}, 32'h0);
    i2c_start();
    write_byte(8'h4F, 8, ack);
    check("rd_raddr_ack", {31'h0, ack}, 32'h0);
    read_byte(1'b0, rd);
    check("rd_byte0", {24'h0, rd}, 32'hA5);
    read_byte(1'b1, rd);
    check("rd_byte1", {24'h0, rd}, 32'hA5);
    tick(h);
    check("rd_oe_after_nack", {31'h0, sda_oe}, 32'h0);
    check("rd_state_ignore", {29'h0, fsm_state}, {29'h0, S_IGNORE});
    i2c_stop();
    tick(20);
    check("rd_state_idle", {29'h0, fsm_state}, {29'h0, S_IDLE});

    // SCL glitch inside a data byte, then STOP after 4 bits of the next byte.
    dv_snap = dv_cnt;
    i2c_start();
    write_byte(8'h4E, 8, ack);
    check("gl_addr_ack", {31'h0, ack}, 32'h0);
    exp_q.push_back(8'h96);
    write_byte(8'h96, 3, ack);
    check("gl_data_ack", {31'h0, ack}, 32'h0);
    check("gl_data_out", {24'h0, data_out}, 32'h96);
    for (int i = 7; i >= 4; i--) send_bit(i[0], 1'b0);
    i2c_stop();
    tick(20);
    check("ps_dv_pulses", dv_cnt - dv_snap, 32'd1);
    check("ps_data_out",  {24'h0, data_out}, 32'h96);
    check("ps_state",     {29'h0, fsm_state}, {29'h0, S_IDLE});
    check("ps_busy",      {31'h0, busy}, 32'h0);

    // Reset while acknowledging a written byte, then a fresh write.
    i2c_start();
    write_byte(8'h4E, 8, ack);
    check("rs_addr_ack", {31'h0, ack}, 32'h0);
    exp_q.push_back(8'h3C);
    for (int i = 7; i >= 0; i--) send_bit(8'h3C >> i, 1'b0);
    check("rs_pre_oe",    {31'h0, sda_oe}, 32'h1);
    check("rs_pre_state", {29'h0, fsm_state}, {29'h0, S_WDATA_ACK});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rs_async_oe",   {31'h0, sda_oe}, 32'h0);
    check("rs_state_idle", {29'h0, fsm_state}, {29'h0, S_IDLE});
    check("rs_data_out",   {24'h0, data_out}, 32'h0);
    sda_m = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(20);
    i2c_start();
    write_byte(8'h4E, 8, ack);
    check("rs2_addr_ack", {31'h0, ack}, 32'h0);
    exp_q.push_back(8'h81);
    write_byte(8'h81, 8, ack);
    check("rs2_data_ack", {31'h0, ack}, 32'h0);
    check("rs2_data_out", {24'h0, data_out}, 32'h81);
    i2c_stop();
    tick(20);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    check("protocol_viol",  viol_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h27, the 7-bit I2C address this target answers to.
REQ-002 SHALL have parameter FILTER_LEN, default 4, the number of consecutive clk samples a bus level must hold before it is accepted.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port scl_in, input, 1 bit: raw SCL from the bus, asynchronous to clk.
REQ-006 SHALL have port sda_in, input, 1 bit: raw SDA from the bus, asynchronous to clk.
REQ-007 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low (open-drain); 0 releases SDA.
REQ-008 SHALL have port data_out, output, 8 bits: last data byte received in a write transfer.
REQ-009 SHALL have port data_valid, output, 1 bit: one-clk pulse when data_out is updated.
REQ-010 SHALL have port busy, output, 1 bit: 1 from an accepted START until an accepted STOP.
REQ-011 SHALL have port addr_hit, output, 1 bit: 1 while the current transfer is addressed to TARGET_ADDR.

Function
REQ-012 SHALL pass scl_in and sda_in through a 2-flop synchronizer, then a filter that updates each filtered level only after FILTER_LEN identical consecutive samples.
REQ-013 SHALL detect START (including repeated START) as filtered SDA 1->0 while filtered SCL is 1.
REQ-014 SHALL detect STOP as filtered SDA 0->1 while filtered SCL is 1.
REQ-015 SHALL sample data bits MSB-first on filtered SCL rising edges.
REQ-016 SHALL change any SDA value it drives only on filtered SCL falling edges.
REQ-017 SHALL use an FSM with states IDLE, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-018 FSM transitions SHALL be as follows:
- IDLE -> ADDR on START.
- ADDR: shift 8 bits. On the falling edge after bit 8, if bits[7:1]==TARGET_ADDR, set sda_oe=1 and addr_hit=1 and go to ADDR_ACK; otherwise go to IGNORE.
- ADDR_ACK: on the next falling edge, release sda_oe. If R/W=0 go to WDATA. If R/W=1, drive bit 7 of the tx byte and go to RDATA.
- WDATA: after 8 bits, on the next falling edge set data_out to the byte, pulse data_valid in the same clk, set sda_oe=1, and go to WDATA_ACK.
- WDATA_ACK: on the next falling edge, release sda_oe and return to WDATA.
- RDATA: tx byte = current data_out. Drive sda_oe = ~bit. After 8 bits, release on the falling edge and go to RDATA_ACK.
- RDATA_ACK: sample the master bit on the rising edge. ACK (0): on the falling edge, drive bit 7 again and go to RDATA. NACK (1): go to IGNORE.
- IGNORE: sda_oe=0; wait for START or STOP.
REQ-019 START in any non-IDLE state SHALL abort the current state, discard any partial byte, release sda_oe, clear addr_hit, and enter ADDR.
REQ-020 STOP in any state SHALL discard any partial byte without a data_valid pulse, release sda_oe, clear addr_hit and busy, and enter IDLE.
REQ-021 General-call address 0x00 SHALL be treated as a non-matching address (no ACK).
REQ-022 data_valid SHALL be exactly 1 clk wide and SHALL never assert outside WDATA completion.
REQ-023 sda_oe SHALL never be 1 while the FSM is in IDLE or IGNORE.
REQ-024 Bit counter SHALL be 3 bits; it is reset to 0 on START and on entry to every data state.

Reset
REQ-025 While rst=0, the block SHALL immediately (asynchronously) set sda_oe=0, data_out=8'h00, data_valid=0, busy=0, addr_hit=0, FSM=IDLE, and set filter and synchronizer outputs to 1.
REQ-026 After rst is released, the block SHALL ignore any transfer already in progress until the next START.

Verification
REQ-027 Write addr byte 0x4E, then data 0x0C and 0x08, then STOP (FILTER_LEN=4, SCL half-period 500 clk) -> three ACKs seen, data_out=0x0C then 0x08, exactly two data_valid pulses, busy back to 0.
REQ-028 Addr byte 0x7E followed by data 0x55 -> SDA never pulled low, addr_hit=0, no data_valid pulse.
REQ-029 Write 0xA5 to 0x27, then repeated START, 0x4F, master ACKs the first byte and NACKs the second -> SDA carries 0xA5 twice, sda_oe=0 after the NACK, FSM=IGNORE until STOP.
REQ-030 A 2-clk low glitch on scl_in during WDATA -> no extra bit shifted, received byte is correct.
REQ-031 STOP after 4 data bits of the second byte -> no data_valid pulse, data_out keeps the first byte, FSM=IDLE.
REQ-032 rst asserted while sda_oe=1 in WDATA_ACK -> sda_oe=0 in the same cycle; after release, the next valid write is received correctly.
